// File: rtl/victim_cache_ctrl.sv
// Victim cache controller: sequences an external tag store through probe (swap-out)
// and insert (with round-robin victim selection and dirty writeback) transactions.
module victim_cache_ctrl #(
  parameter int TAG_WIDTH = 4,
  parameter int NUM_WAYS  = 4,
  localparam int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic [TAG_WIDTH-1:0] req_tag,
  input  logic                 req_dirty,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [WAY_W-1:0]     resp_way,
  output logic                 resp_dirty,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [TAG_WIDTH-1:0] wb_tag,
  output logic                 ts_write_en,
  output logic                 ts_read_en,
  output logic                 ts_lookup_en,
  output logic                 ts_valid_clear,
  output logic                 ts_dirty_set,
  output logic                 ts_dirty_clear,
  output logic [TAG_WIDTH-1:0] ts_tag,
  output logic [WAY_W-1:0]     ts_way,
  input  logic                 ts_hit,
  input  logic [WAY_W-1:0]     ts_hit_way,
  input  logic                 ts_valid_read,
  input  logic                 ts_dirty_read,
  input  logic [TAG_WIDTH-1:0] ts_tag_read,
  output logic [3:0]           dbg_state
);

  // Handshakes: a request transfers on a cycle where req_valid && req_ready (only
  // in IDLE); a writeback transfers where wb_valid && wb_ready, and wb_valid/wb_tag
  // hold steady until then; resp_valid is a single-cycle pulse with no back-pressure.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOOKUP = 4'd1,
    S_HIT_RD = 4'd2,
    S_INVAL  = 4'd3,
    S_VIC_RD = 4'd4,
    S_WB     = 4'd5,
    S_WRITE  = 4'd6,
    S_DSET   = 4'd7,
    S_RESP   = 4'd8
  } state_t;

  state_t               state, state_nxt;
  logic                 op_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 dirty_q;
  logic                 hit_q;
  logic [WAY_W-1:0]     way_q;
  logic                 line_dirty_q;
  logic [TAG_WIDTH-1:0] wb_tag_q;
  logic [WAY_W-1:0]     rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      op_q         <= 1'b0;
      tag_q        <= '0;
      dirty_q      <= 1'b0;
      hit_q        <= 1'b0;
      way_q        <= '0;
      line_dirty_q <= 1'b0;
      wb_tag_q     <= '0;
      rr_ptr       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q         <= req_op;
            tag_q        <= req_tag;
            dirty_q      <= req_dirty;
            line_dirty_q <= 1'b0;
          end
        end
        S_LOOKUP: begin
          // A probe miss reports way 0; an insert miss targets the round-robin way.
          hit_q <= ts_hit;
          if (ts_hit)    way_q <= ts_hit_way;
          else if (op_q) way_q <= rr_ptr;
          else           way_q <= '0;
        end
        S_HIT_RD: line_dirty_q <= ts_dirty_read;
        S_VIC_RD: begin
          if (ts_valid_read && ts_dirty_read) wb_tag_q <= ts_tag_read;
        end
        S_WRITE: begin
          if (!hit_q) rr_ptr <= rr_ptr + WAY_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt      = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_hit       = 1'b0;
    resp_way       = '0;
    resp_dirty     = 1'b0;
    wb_valid       = 1'b0;
    wb_tag         = '0;
    ts_write_en    = 1'b0;
    ts_read_en     = 1'b0;
    ts_lookup_en   = 1'b0;
    ts_valid_clear = 1'b0;
    ts_dirty_set   = 1'b0;
    ts_dirty_clear = 1'b0;
    ts_tag         = '0;
    ts_way         = '0;
    dbg_state      = '0;
    // Every output is held at zero while rst is high, regardless of current state.
    if (!rst) begin
      dbg_state = state;
      case (state)
        S_IDLE: begin
          req_ready = 1'b1;
          if (req_valid) state_nxt = S_LOOKUP;
        end
        S_LOOKUP: begin
          ts_lookup_en = 1'b1;
          ts_tag       = tag_q;
          if (ts_hit) state_nxt = op_q ? S_WRITE : S_HIT_RD;
          else        state_nxt = op_q ? S_VIC_RD : S_RESP;
        end
        S_HIT_RD: begin
          ts_read_en = 1'b1;
          ts_way     = way_q;
          state_nxt  = S_INVAL;
        end
        S_INVAL: begin
          ts_valid_clear = 1'b1;
          ts_way         = way_q;
          state_nxt      = S_RESP;
        end
        S_VIC_RD: begin
          ts_read_en = 1'b1;
          ts_way     = way_q;
          state_nxt  = (ts_valid_read && ts_dirty_read) ? S_WB : S_WRITE;
        end
        S_WB: begin
          wb_valid = 1'b1;
          wb_tag   = wb_tag_q;
          if (wb_ready) state_nxt = S_WRITE;
        end
        S_WRITE: begin
          ts_write_en = 1'b1;
          ts_tag      = tag_q;
          ts_way      = way_q;
          state_nxt   = dirty_q ? S_DSET : S_RESP;
        end
        S_DSET: begin
          ts_dirty_set = 1'b1;
          ts_way       = way_q;
          state_nxt    = S_RESP;
        end
        S_RESP: begin
          resp_valid = 1'b1;
          resp_hit   = hit_q;
          resp_way   = way_q;
          resp_dirty = op_q ? dirty_q : line_dirty_q;
          state_nxt  = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Bench for victim_cache_ctrl: behavioural tag store, transaction-level victim cache
// model feeding expected queues, and a negedge monitor that pops and compares.
module tb_victim_cache_ctrl;
  localparam int TW = 4;
  localparam int NW = 4;
  localparam int WW = 2;
  localparam int EW = 40; // {handshake cycle[31:0], latency[3:0], hit, way[1:0], dirty}

  logic          clk, rst;
  logic          req_valid, req_ready, req_op, req_dirty;
  logic [TW-1:0] req_tag;
  logic          resp_valid, resp_hit, resp_dirty;
  logic [WW-1:0] resp_way;
  logic          wb_valid, wb_ready;
  logic [TW-1:0] wb_tag;
  logic          ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear;
  logic [TW-1:0] ts_tag, ts_tag_read;
  logic [WW-1:0] ts_way, ts_hit_way;
  logic          ts_hit, ts_valid_read, ts_dirty_read;
  logic [3:0]    dbg_state;
  logic [26:0]   out_vec;

  victim_cache_ctrl #(.TAG_WIDTH(TW), .NUM_WAYS(NW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_tag(req_tag),
    .req_dirty(req_dirty),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way), .resp_dirty(resp_dirty),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
    .ts_write_en(ts_write_en), .ts_read_en(ts_read_en), .ts_lookup_en(ts_lookup_en),
    .ts_valid_clear(ts_valid_clear), .ts_dirty_set(ts_dirty_set), .ts_dirty_clear(ts_dirty_clear),
    .ts_tag(ts_tag), .ts_way(ts_way), .ts_hit(ts_hit), .ts_hit_way(ts_hit_way),
    .ts_valid_read(ts_valid_read), .ts_dirty_read(ts_dirty_read), .ts_tag_read(ts_tag_read),
    .dbg_state(dbg_state)
  );

  assign out_vec = {req_ready, resp_valid, resp_hit, resp_way, resp_dirty, wb_valid, wb_tag,
                    ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set,
                    ts_dirty_clear, ts_tag, ts_way, dbg_state};

  // ---------------- clock / reset / cycle count ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d required < 50000", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- tag store environment ----------------
  logic          st_v[NW];
  logic          st_d[NW];
  logic [TW-1:0] st_t[NW];
  bit            store_clr;

  always @(posedge clk) begin
    if (store_clr) begin
      for (int i = 0; i < NW; i++) begin
        st_v[i] <= 1'b0;
        st_d[i] <= 1'b0;
        st_t[i] <= '0;
      end
    end else begin
      if (ts_write_en) begin
        st_t[ts_way] <= ts_tag;
        st_v[ts_way] <= 1'b1;
        st_d[ts_way] <= 1'b0;
      end
      if (ts_valid_clear) st_v[ts_way] <= 1'b0;
      if (ts_dirty_set)   st_d[ts_way] <= 1'b1;
      if (ts_dirty_clear) st_d[ts_way] <= 1'b0;
    end
  end

  always_comb begin
    ts_hit     = 1'b0;
    ts_hit_way = '0;
    for (int i = 0; i < NW; i++) begin
      if (st_v[i] === 1'b1 && st_t[i] == ts_tag && !ts_hit) begin
        ts_hit     = 1'b1;
        ts_hit_way = 2'(i);
      end
    end
    ts_valid_read = st_v[ts_way];
    ts_dirty_read = st_d[ts_way];
    ts_tag_read   = st_t[ts_way];
  end

  // writeback acceptor: holds wb_ready low for wb_target cycles of each writeback
  int force_stall = -1;
  int wb_cnt, wb_target;
  initial begin
    wb_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!wb_valid) begin
        wb_cnt    = 0;
        wb_target = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
        wb_ready  = 1'b0;
      end else begin
        wb_cnt++;
        wb_ready = (wb_cnt > wb_target);
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [TW-1:0] wb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_v[NW], m_d[NW], s_v[NW], s_d[NW];
  logic [TW-1:0] m_t[NW], s_t[NW];
  int          m_rr = 0;

  task automatic model_op(input bit op, input logic [TW-1:0] tag, input bit d, input int hs,
                          output logic [EW-1:0] e, output bit has_wb, output logic [TW-1:0] wbt);
    int hw, w, lat;
    bit hit, edirty;
    hw = -1; has_wb = 0; wbt = '0;
    for (int i = 0; i < NW; i++) if (m_v[i] && m_t[i] == tag && hw < 0) hw = i;
    if (!op) begin
      if (hw >= 0) begin
        hit = 1; w = hw; edirty = m_d[hw]; lat = 4; m_v[hw] = 0;
      end else begin
        hit = 0; w = 0; edirty = 0; lat = 2;
      end
    end else if (hw >= 0) begin
      hit = 1; w = hw; edirty = d; lat = 3 + int'(d); m_d[hw] = d;
    end else begin
      w = m_rr; hit = 0; edirty = d;
      has_wb = m_v[w] && m_d[w];
      wbt = m_t[w];
      lat = (has_wb ? 5 : 4) + int'(d);
      m_v[w] = 1; m_t[w] = tag; m_d[w] = d;
      m_rr = (m_rr + 1) % NW;
    end
    e = {32'(hs), 4'(lat), hit, 2'(w), edirty};
  endtask

  // ---------------- monitor ----------------
  int lk = 0, stall = 0, wb_run = 0, last_wb_len = 0;
  logic [WW-1:0] last_wr_way, last_clr_way;
  logic [TW-1:0] last_wr_tag;

  initial begin
    logic [EW-1:0] e;
    int ns;
    forever begin
      @(negedge clk);
      if (rst) begin
        lk = 0; stall = 0; wb_run = 0;
      end else begin
        ns = int'(ts_write_en) + int'(ts_read_en) + int'(ts_lookup_en) + int'(ts_valid_clear)
           + int'(ts_dirty_set) + int'(ts_dirty_clear);
        chk(ns <= 1 && !ts_dirty_clear && (ns != 0 || (ts_tag == '0 && ts_way == '0)),
            "ts_strobe_rules", {ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear,
            ts_dirty_set, ts_dirty_clear, ts_tag, ts_way}, 0);
        if (ts_lookup_en) lk++;
        if (ts_write_en) begin
          last_wr_way = ts_way;
          last_wr_tag = ts_tag;
        end
        if (ts_valid_clear) last_clr_way = ts_way;
        if (wb_valid) begin
          wb_run++;
          if (!wb_ready) stall++;
          if (wb_q.size() == 0) chk(1'b0, "unexpected_wb", wb_tag, 0);
          else chk(wb_tag == wb_q[0], "wb_tag", wb_tag, wb_q[0]);
          if (wb_ready) begin
            last_wb_len = wb_run;
            if (wb_q.size() != 0) void'(wb_q.pop_front());
          end
        end else begin
          wb_run = 0;
        end
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_resp", {resp_hit, resp_way, resp_dirty}, 0);
          end else begin
            e = exp_q.pop_front();
            chk(resp_hit == e[3], "resp_hit", resp_hit, e[3]);
            chk(resp_way == e[2:1], "resp_way", resp_way, e[2:1]);
            chk(resp_dirty == e[0], "resp_dirty", resp_dirty, e[0]);
            chk(cyc - int'(e[39:8]) == int'(e[7:4]) + stall, "resp_latency",
                cyc - int'(e[39:8]), int'(e[7:4]) + stall);
            chk(lk == 1, "lookup_count", lk, 1);
          end
          lk = 0; stall = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_req(input bit op, input logic [TW-1:0] tag, input bit d, output bit ok);
    logic [EW-1:0] e;
    bit hw;
    logic [TW-1:0] wt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_tag = tag; req_dirty = d;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!ok) begin
      chk(1'b0, "req_ready_timeout", 0, 1);
      req_valid = 1'b0;
    end else begin
      model_op(op, tag, d, cyc, e, hw, wt);
      exp_q.push_back(e);
      if (hw) wb_q.push_back(wt);
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  // Waits for the response while scrambling req_* to show they are ignored when busy.
  task automatic wait_resp();
    bit done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(posedge clk); #1;
      req_valid = 1'($urandom);
      req_op    = 1'($urandom);
      req_tag   = 4'($urandom);
      req_dirty = 1'($urandom);
      @(negedge clk);
      if (resp_valid) begin
        req_valid = 1'b0;
        done = 1;
      end
    end
    req_valid = 1'b0;
    if (!done) begin
      chk(1'b0, "resp_timeout", 0, 1);
      exp_q.delete();
      wb_q.delete();
    end
  endtask

  task automatic issue(input bit op, input logic [TW-1:0] tag, input bit d);
    bit ok;
    start_req(op, tag, d, ok);
    if (ok) wait_resp();
  endtask

  task automatic do_reset(input int n, input bit clear_store);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0; store_clr = clear_store;
    exp_q.delete();
    wb_q.delete();
    repeat (n) begin
      @(negedge clk);
      chk(out_vec == '0, "outputs_in_reset", out_vec, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; store_clr = 1'b0;
    @(negedge clk);
    chk(req_ready == 1'b1, "req_ready_after_reset", req_ready, 1);
    if (clear_store) begin
      for (int i = 0; i < NW; i++) begin
        m_v[i] = 0; m_d[i] = 0; m_t[i] = '0;
      end
    end
    m_rr = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok, seen;
    rst = 1'b1; store_clr = 1'b1;
    req_valid = 1'b0; req_op = 1'b0; req_tag = '0; req_dirty = 1'b0;
    do_reset(3, 1);

    // probe on empty store
    issue(0, 4'h5, 0);

    // fill ways 0..3 clean, fifth insert reuses way 0, sixth goes to way 1
    for (int t = 1; t <= 4; t++) issue(1, 4'(t), 0);
    issue(1, 4'h9, 0);
    chk(last_wr_way == 2'd0 && last_wr_tag == 4'h9, "wrap_write_way0", {last_wr_way, last_wr_tag}, 8'h09);
    issue(1, 4'h7, 0);
    chk(last_wr_way == 2'd1, "rr_after_wrap", last_wr_way, 1);

    // dirty victim with three stall cycles
    do_reset(2, 1);
    issue(1, 4'hA, 1);
    issue(1, 4'h1, 0);
    issue(1, 4'h3, 1);
    issue(1, 4'h4, 0);
    force_stall = 3;
    issue(1, 4'hB, 0);
    force_stall = -1;
    chk(last_wb_len == 4, "wb_held_cycles", last_wb_len, 4);
    chk(last_wr_way == 2'd0 && last_wr_tag == 4'hB, "write_after_wb", {last_wr_way, last_wr_tag}, 8'h0B);

    // duplicate insert, then probe hit and re-probe miss, then round-robin continues at way 1
    issue(1, 4'h3, 1);
    chk(last_wr_way == 2'd2, "dup_write_way", last_wr_way, 2);
    issue(0, 4'h3, 0);
    chk(last_clr_way == 2'd2, "probe_clear_way", last_clr_way, 2);
    issue(0, 4'h3, 0);
    issue(1, 4'hC, 0);
    chk(last_wr_way == 2'd1, "rr_unchanged_by_dup", last_wr_way, 1);

    // reset while a writeback is pending
    do_reset(2, 1);
    issue(1, 4'hD, 1);
    issue(1, 4'hE, 0);
    issue(1, 4'hF, 0);
    issue(1, 4'h1, 0);
    s_v = m_v; s_d = m_d; s_t = m_t;
    force_stall = 1000;
    start_req(1, 4'h2, 0, ok);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (wb_valid) seen = 1;
    end
    chk(seen, "wb_before_reset", seen, 1);
    do_reset(2, 0);
    m_v = s_v; m_d = s_d; m_t = s_t;
    force_stall = -1;
    repeat (4) @(posedge clk);
    issue(1, 4'h6, 0);
    chk(last_wr_way == 2'd0 && last_wr_tag == 4'h6, "insert_after_reset", {last_wr_way, last_wr_tag}, 8'h06);

    // randomized traffic over a small tag space for frequent hits and evictions
    for (int k = 0; k < 250; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      issue(1'($urandom), 4'($urandom_range(0, 7)), 1'($urandom));
    end

    repeat (5) @(posedge clk);
    chk(exp_q.size() == 0, "resp_queue_drained", exp_q.size(), 0);
    chk(wb_q.size() == 0, "wb_queue_drained", wb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/victim_cache_ctrl.md
VICTIM_CACHE_CTRL -- requirements
Module: victim_cache_ctrl

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 4, tag width in bits.
REQ-002 SHALL have parameter NUM_WAYS, default 4, tag-store ways (power of 2); WAY_W = $clog2(NUM_WAYS).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports (name  direction  width  meaning):
 clk  in  1  clock, rising edge
 rst  in  1  synchronous active-high reset
 req_valid  in  1  request offered
 req_ready  out  1  controller can accept
 req_op  in  1  0=probe (L1 miss), 1=insert (L1 eviction)
 req_tag  in  TAG_WIDTH  request tag
 req_dirty  in  1  inserted line dirty
 resp_valid  out  1  one-cycle completion pulse
 resp_hit  out  1  probe hit / insert matched existing tag
 resp_way  out  WAY_W  way used
 resp_dirty  out  1  probe: hit line dirty; insert: req_dirty
 wb_valid  out  1  dirty victim writeback offered
 wb_ready  in  1  memory accepts writeback
 wb_tag  out  TAG_WIDTH  victim tag
 ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear  out  1 each  tag-store strobes
 ts_tag  out  TAG_WIDTH  tag to store
 ts_way  out  WAY_W  way index to store
 ts_hit  in  1  combinational lookup hit
 ts_hit_way  in  WAY_W  hit way
 ts_valid_read, ts_dirty_read  in  1 each  combinational read data
 ts_tag_read  in  TAG_WIDTH  combinational read tag

Function
REQ-005 SHALL implement FSM states IDLE, LOOKUP, HIT_RD, INVAL, VIC_RD, WB, WRITE, DSET, RESP.
REQ-006 SHALL assert req_ready only in IDLE; handshake = req_valid && req_ready; latch op, tag, dirty; go to LOOKUP.
REQ-007 SHALL ignore req_valid outside IDLE; latched values are unaffected by req_* changes.
REQ-008 LOOKUP: ts_lookup_en=1, ts_tag=latched tag; sample ts_hit/ts_hit_way that cycle into hit flag and way register.
REQ-009 Probe hit: LOOKUP->HIT_RD (ts_read_en=1, ts_way=way; capture ts_dirty_read)->INVAL (ts_valid_clear=1)->RESP; line leaves victim cache (swap to L1).
REQ-010 Probe miss: LOOKUP->RESP with resp_hit=0, resp_way=0, resp_dirty=0.
REQ-011 Insert with hit (duplicate tag): LOOKUP->WRITE on matched way; no eviction; rr_ptr unchanged.
REQ-012 Insert miss: way=rr_ptr; LOOKUP->VIC_RD (ts_read_en=1, ts_way=way); if ts_valid_read && ts_dirty_read capture ts_tag_read into wb_tag, go WB; else WRITE.
REQ-013 WB: wb_valid=1, wb_tag stable until wb_valid && wb_ready; then WRITE next cycle; no timeout.
REQ-014 WRITE: ts_write_en=1, ts_tag=latched tag, ts_way=way (store sets valid, clears dirty); then DSET if req_dirty else RESP.
REQ-015 DSET: ts_dirty_set=1, ts_way=way; then RESP.
REQ-016 rr_ptr SHALL increment by 1, mod NUM_WAYS (wraps NUM_WAYS-1 to 0), in WRITE of non-duplicate insert only.
REQ-017 RESP: resp_valid=1 one cycle, resp_hit/resp_way/resp_dirty per REQ-009..REQ-014; next state IDLE.
REQ-018 At most one ts_* strobe SHALL be high per cycle; ts_dirty_clear is never asserted; ts_tag/ts_way SHALL be 0 when no strobe is high.
REQ-019 Latency from handshake to resp_valid: probe miss 2, probe hit 4, insert clean/invalid victim 4 (+1 if dirty), dirty victim 5 + wb stall cycles (+1 if dirty), duplicate 3 (+1 if dirty).

Reset
REQ-020 rst high at a clock edge SHALL force IDLE, rr_ptr=0, clear latched/captured registers; overrides any other event.
REQ-021 During and after reset all outputs SHALL be 0 except req_ready, which SHALL be 1 from the first cycle after rst deasserts.
REQ-022 Reset mid-operation SHALL abandon the request: no resp_valid, wb_valid low next cycle, no further strobes.

Verification
REQ-023 Probe tag 0x5 on empty store -> ts_lookup_en one cycle, resp_valid 2 cycles after handshake, resp_hit=0.
REQ-024 Insert tags 0x1..0x4 clean, then insert 0x9 -> ways 0..3 then way 0 reused; 5th insert reads way 0 (valid, clean), no wb_valid, rr_ptr wraps to 1.
REQ-025 Insert 0xA dirty into way 0, fill ways 1..3, insert 0xB with wb_ready low 3 cycles -> wb_valid held 4 cycles, wb_tag=0xA stable, then ts_write_en way 0 tag 0xB.
REQ-026 Probe 0x3 stored dirty in way 2 -> resp_hit=1, resp_way=2, resp_dirty=1 at latency 4, ts_valid_clear with ts_way=2; re-probe misses.
REQ-027 Insert duplicate 0x3 present in way 2 -> ts_write_en way 2, resp_hit=1, rr_ptr unchanged.
REQ-028 Assert rst during WB -> wb_valid 0 next cycle, no resp_valid, req_ready 1 after release, next insert targets way 0.
